calc_stream_engine: RTL
=======================

// Module: calc_stream_engine
// PURPOSE
//  Parametrised calculator engine for the next-gen calculator top level. It walks a programmed
//  SRAM read range, applies a selectable ALU op to the two operands packed in each word, and
//  packs two results per write word via an internal result buffer. It writes those words back
//  over a programmed write range, with start/busy/done handshake and error/carry status.
//  Sits between the dual-SRAM read/write ports and the top-level config registers.
// PARAMETERS
//  DATA_W  32  operand/result width; memory word is MEM_W = 2*DATA_W (op_a low, op_b high)
//  ADDR_W  9   SRAM word address width
// PORTS
//  clk_i             in   1        clock
//  rst_i             in   1        synchronous reset, active-low
//  start_i           in   1        start pulse; sampled only in IDLE
//  mode_i            in   2        op select, latched at start (calc_mode_e)
//  read_start_addr   in   ADDR_W   first read address (inclusive)
//  read_end_addr     in   ADDR_W   last read address (inclusive)
//  write_start_addr  in   ADDR_W   first write address
//  write_end_addr    in   ADDR_W   last legal write address (inclusive)
//  rd_en_o           out  1        read strobe; rd_data_i valid exactly 1 cycle later
//  rd_addr_o         out  ADDR_W   read address
//  rd_data_i         in   MEM_W    read data {op_b, op_a}
//  wr_en_o           out  1        write strobe, full-word write
//  wr_addr_o         out  ADDR_W   write address
//  wr_data_o         out  MEM_W    write data {result[n+1], result[n]}
//  busy_o            out  1        high from cycle after accepted start until DONE
//  done_o            out  1        one-cycle pulse at end of every run (incl. error runs)
//  err_o             out  1        sticky until next start: bad range or write-range overflow
//  carry_o           out  1        sticky until next start: any ADD carry-out / SUB borrow
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; result buffer, counters and flags cleared. Reset beats any
//   in-flight op: the next edge returns to IDLE and no write is issued after reset is sampled low.
//  FSM: IDLE -> RD -> CALC -> (WR | RD) ... -> DONE -> IDLE.
//   IDLE: start_i=1 latches addresses and mode, clears err/carry and the buffer, and sets busy.
//     If read_end_addr < read_start_addr: set err and go to DONE with no memory access.
//   RD: rd_en_o=1, rd_addr_o=rd_ptr; go to CALC.
//   CALC: result = alu(op_a, op_b). Store it in the lower slot if slot=0, else the upper slot.
//     Toggle slot. Go to WR if slot was 1 or this was the last read; otherwise rd_ptr++ -> RD.
//   WR: if wr_ptr > write_end_addr: err=1, no write, go to DONE. Otherwise wr_en_o=1,
//     wr_addr_o=wr_ptr, wr_ptr++, clear slots. Then RD (rd_ptr++) if reads remain, else DONE.
//   DONE: done_o=1, busy_o=0; go to IDLE.
//  Odd read count: the final word is written with the upper slot = 0.
//  Latency for N reads, no error: 2N + ceil(N/2) cycles from start acceptance to DONE entry.
//  Modes (calc_mode_e): 00 ADD a+b mod 2^DATA_W; 01 SUB a-b mod 2^DATA_W, borrow when a<b;
//   10 ADDSAT unsigned a+b clamped to all-ones, carry still flagged; 11 XOR a^b, no carry.
//  start_i while busy is ignored. Address pointers never wrap: read_end_addr = 2^ADDR_W-1 is
//   legal and terminates the read loop without pointer overflow.
//  rd_addr_o/wr_addr_o/wr_data_o hold their last value when strobes are low.
// STRUCTURE
//  calculator_pkg: calc_mode_e (2-bit enum), calc_state_e (IDLE,RD,CALC,WR,DONE), MEM_W helper.
//  Sub-module calc_alu (combinational): DATA_W param; in: a, b, mode; out: result, carry.
//  The FSM, pointers and 2-slot result buffer stay in calc_stream_engine.
// TESTING
//  1 ADD, rd 0..3 = {2,1},{5,4},{FFFFFFFF,1},{0,0}, wr 8..9 -> wr[8]={9,3}, wr[9]={0,0},
//    carry_o=1, err_o=0, done at cycle 10.
//  2 SUB, rd single word {5,3} at addr 7 -> one write {0,FFFFFFFE}, carry_o=1, upper slot 0.
//  3 ADDSAT {1,FFFFFFFF} -> result FFFFFFFF, carry=1; XOR {F0F0,0FF0} -> FF00, carry=0.
//  4 Errors: rd 0..5, wr 4..4 -> one write at 4, then err_o=1, done, no second write;
//    read_end < read_start -> done next cycle, err_o=1, rd_en_o never asserted.
//  5 rst_i=0 during WR cycle -> next cycle outputs all 0, IDLE; restart completes cleanly.
//  6 start_i pulsed while busy -> ignored; one done_o pulse per accepted start.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared types for the calculator stream engine:
// ALU mode and FSM state encodings, memory word width helper.
package calculator_pkg;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'b00,
    MODE_SUB    = 2'b01,
    MODE_ADDSAT = 2'b10,
    MODE_XOR    = 2'b11
  } calc_mode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CALC = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } calc_state_e;

  function automatic int mem_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: add, subtract, saturating add, xor.
// carry flags ADD/ADDSAT carry-out and SUB borrow.
module calc_alu
  import calculator_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  calc_mode_e        mode,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // Select the operation result and its carry/borrow flag
  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (mode)
      MODE_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      MODE_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      MODE_ADDSAT: begin
        result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      MODE_XOR: begin
        result = a ^ b;
        carry  = 1'b0;
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_stream_engine.sv
// Streams a read range through the ALU, packing two results
// per write word, with busy/done handshake and sticky status.
module calc_stream_engine
  import calculator_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  localparam int MEM_W = mem_w(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] read_start_addr,
  input  logic [ADDR_W-1:0] read_end_addr,
  input  logic [ADDR_W-1:0] write_start_addr,
  input  logic [ADDR_W-1:0] write_end_addr,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [MEM_W-1:0]  rd_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [MEM_W-1:0]  wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              carry_o
);

  calc_state_e state, state_nx;
  calc_mode_e  mode;

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_end;
  // one extra bit so the pointer cannot wrap past the top address
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W-1:0] wr_end;

  logic [DATA_W-1:0] slot_lo;
  logic [DATA_W-1:0] slot_hi;
  logic              slot;
  logic              err;
  logic              carry;

  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [MEM_W-1:0]  wr_data_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              bad_range;
  logic              last_rd;
  logic              wr_ovf;

  assign bad_range = (read_end_addr < read_start_addr);
  assign last_rd   = (rd_ptr == rd_end);
  assign wr_ovf    = (wr_ptr > {1'b0, wr_end});

  calc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (rd_data_i[DATA_W-1:0]),
    .b      (rd_data_i[MEM_W-1:DATA_W]),
    .mode   (mode),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_i) state_nx = bad_range ? DONE : RD;
      end
      RD:   state_nx = CALC;
      CALC: state_nx = (slot || last_rd) ? WR : RD;
      WR:   state_nx = (wr_ovf || last_rd) ? DONE : RD;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: strobes from state, addresses/data hold when idle
  always_comb begin
    rd_en_o   = (state == RD);
    wr_en_o   = (state == WR) && !wr_ovf;
    busy_o    = (state == RD) || (state == CALC)
             || (state == WR);
    done_o    = (state == DONE);
    err_o     = err;
    carry_o   = carry;
    rd_addr_o = rd_en_o ? rd_ptr : rd_addr_q;
    wr_addr_o = wr_en_o ? wr_ptr[ADDR_W-1:0] : wr_addr_q;
    wr_data_o = wr_en_o ? {slot_hi, slot_lo} : wr_data_q;
  end

  // Datapath: pointers, result slots, status and held outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mode      <= MODE_ADD;
      rd_ptr    <= '0;
      rd_end    <= '0;
      wr_ptr    <= '0;
      wr_end    <= '0;
      slot_lo   <= '0;
      slot_hi   <= '0;
      slot      <= 1'b0;
      err       <= 1'b0;
      carry     <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            mode    <= calc_mode_e'(mode_i);
            rd_ptr  <= read_start_addr;
            rd_end  <= read_end_addr;
            wr_ptr  <= {1'b0, write_start_addr};
            wr_end  <= write_end_addr;
            slot_lo <= '0;
            slot_hi <= '0;
            slot    <= 1'b0;
            err     <= bad_range;
            carry   <= 1'b0;
          end
        end
        RD: rd_addr_q <= rd_ptr;
        CALC: begin
          if (slot) slot_hi <= alu_res;
          else      slot_lo <= alu_res;
          slot  <= ~slot;
          carry <= carry | alu_carry;
          if (!slot && !last_rd)
            rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        WR: begin
          if (wr_ovf) begin
            err <= 1'b1;
          end else begin
            wr_addr_q <= wr_ptr[ADDR_W-1:0];
            wr_data_q <= {slot_hi, slot_lo};
            wr_ptr    <= wr_ptr + (ADDR_W+1)'(1);
            slot_lo   <= '0;
            slot_hi   <= '0;
            slot      <= 1'b0;
            if (!last_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
